// File: rtl/fetch_queue.sv
// Fetch stage with an instruction queue: issues sequential reads to a 1-cycle
// program memory, buffers {instr, pc} entries, and hands them to decode via valid/ready.
module fetch_queue #(
    parameter int              PC_W     = 5,
    parameter int              INSTR_W  = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         jump_valid,
    input  logic [PC_W-1:0]              jump_dest,
    input  logic                         branch_taken,
    input  logic [PC_W-1:0]              branch_dest,
    output logic                         mem_req,
    output logic [PC_W-1:0]              mem_addr,
    input  logic [INSTR_W-1:0]           mem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [PC_W-1:0]              out_pc,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

    localparam int CNT_W  = $clog2(QDEPTH + 1);
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int ROOM_W = CNT_W + 1;

    logic [PC_W-1:0]    fpc_q, fpc_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] instr_mem_q [QDEPTH];
    logic [PC_W-1:0]    pc_mem_q    [QDEPTH];

    logic               redirect_s;
    logic [PC_W-1:0]    target_s;
    logic               pop_s;
    logic               push_s;
    logic [ROOM_W-1:0]  occ_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QDEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Redirect decode, handshake, issue decision and head presentation.
    always_comb begin
        redirect_s = jump_valid | branch_taken;
        target_s   = jump_valid ? jump_dest : branch_dest;
        out_valid  = (count_q != {CNT_W{1'b0}}) & ~redirect_s;
        pop_s      = out_valid & out_ready;
        push_s     = inflight_q & ~redirect_s;
        // Occupancy after this cycle's pop, counting the read already in flight.
        occ_s      = ROOM_W'(count_q) + ROOM_W'(inflight_q) - ROOM_W'(pop_s);
        mem_req    = ~rst & ~redirect_s & (occ_s < ROOM_W'(QDEPTH));
        mem_addr   = fpc_q;
        q_count    = count_q;
        if (count_q != {CNT_W{1'b0}}) begin
            out_instr = instr_mem_q[rd_ptr_q];
            out_pc    = pc_mem_q[rd_ptr_q];
        end else begin
            out_instr = {INSTR_W{1'b0}};
            out_pc    = {PC_W{1'b0}};
        end
    end

    // Next-state for fetch PC, in-flight tracking and queue pointers.
    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect_s) begin
            // Flush; clearing inflight drops the read that returns next cycle.
            fpc_d    = target_s;
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (mem_req) begin
                fpc_d         = fpc_q + PC_W'(1);
                inflight_d    = 1'b1;
                inflight_pc_d = fpc_q;
            end else begin
                inflight_d    = 1'b0;
            end
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {PC_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            wr_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are only visible through count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            instr_mem_q[wr_ptr_q] <= mem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push expected PCs, a
// negedge monitor pops and checks every completed handshake.
module tb_fetch_queue;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 32;
    localparam int QDEPTH  = 4;
    localparam int CNT_W   = $clog2(QDEPTH + 1);

    logic               clk;
    logic               rst;
    logic               jump_valid;
    logic [PC_W-1:0]    jump_dest;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_dest;
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [CNT_W-1:0]   q_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_del  = 0;
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] mon_pc;

    fetch_queue #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH), .RESET_PC(5'd0)
    ) dut (
        .clk(clk), .rst(rst),
        .jump_valid(jump_valid), .jump_dest(jump_dest),
        .branch_taken(branch_taken), .branch_dest(branch_dest),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] word(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | INSTR_W'(a);
    endfunction

    // Program memory model with one cycle of read latency.
    always @(posedge clk) begin
        mem_rdata <= mem_req ? word(mem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head must match the next expected PC and its word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_del++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_delivery: got pc %0d, nothing expected", out_pc);
            end else begin
                mon_pc = exp_q.pop_front();
                chk("deliver_pc", 64'(out_pc), 64'(mon_pc));
                chk("deliver_instr", 64'(out_instr), 64'(word(mon_pc)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input int start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(PC_W'(start + i));
    endtask

    task automatic do_reset(input logic rdy);
        rst          = 1'b1;
        jump_valid   = 1'b0;
        branch_taken = 1'b0;
        jump_dest    = 5'd0;
        branch_dest  = 5'd0;
        out_ready    = rdy;
        exp_q.delete();
        step();
        step();
        rst   = 1'b0;
        n_del = 0;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; jump_valid = 1'b0; branch_taken = 1'b0;
        jump_dest = 5'd0; branch_dest = 5'd0;

        // Streaming from reset with decode always ready.
        do_reset(1'b1);
        expect_run(0, 12);
        for (int k = 0; k < 12; k++) begin
            #1;
            if (k == 0) begin
                chk("rst_q_count", 64'(q_count), 64'd0);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_pc", 64'(out_pc), 64'd0);
                chk("rst_out_instr", 64'(out_instr), 64'd0);
                chk("rst_mem_req", 64'(mem_req), 64'd1);
                chk("rst_mem_addr", 64'(mem_addr), 64'd0);
            end
            if (k == 1) chk("p1_c1_valid", 64'(out_valid), 64'd0);
            if (k == 2) begin
                chk("p1_c2_valid", 64'(out_valid), 64'd1);
                chk("p1_c2_pc", 64'(out_pc), 64'd0);
            end
            chk("p1_count_le1", 64'(q_count <= 1), 64'd1);
            step();
        end
        out_ready = 1'b0;
        chk("p1_delivered", 64'(n_del), 64'd10);

        // Backpressure: fill to QDEPTH, then drain.
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k == 3) chk("p2_c3_mem_req", 64'(mem_req), 64'd1);
            if (k == 4) chk("p2_c4_mem_req", 64'(mem_req), 64'd0);
            if (k == 9) begin
                chk("p2_full_count", 64'(q_count), 64'd4);
                chk("p2_full_mem_req", 64'(mem_req), 64'd0);
                chk("p2_full_valid", 64'(out_valid), 64'd1);
                chk("p2_full_pc", 64'(out_pc), 64'd0);
            end
            step();
        end
        expect_run(0, 16);
        out_ready = 1'b1;
        for (int k = 10; k < 20; k++) step();
        out_ready = 1'b0;
        chk("p2_delivered", 64'(n_del), 64'd10);

        // Flush with PCs 5..7 queued and 8 in flight.
        do_reset(1'b0);
        jump_valid = 1'b1; jump_dest = 5'd5;
        #1;
        chk("p3_c0_mem_req", 64'(mem_req), 64'd0);
        step();
        jump_valid = 1'b0;
        for (int k = 1; k < 5; k++) step();
        chk("p3_c5_count", 64'(q_count), 64'd3);
        chk("p3_c5_head", 64'(out_pc), 64'd5);
        expect_run(15, 10);
        jump_valid = 1'b1; jump_dest = 5'd15; out_ready = 1'b1;
        #1;
        chk("p3_redir_valid", 64'(out_valid), 64'd0);
        chk("p3_redir_mem_req", 64'(mem_req), 64'd0);
        step();
        jump_valid = 1'b0;
        #1;
        chk("p3_c6_valid", 64'(out_valid), 64'd0);
        chk("p3_c6_count", 64'(q_count), 64'd0);
        chk("p3_c6_addr", 64'(mem_addr), 64'd15);
        step();
        #1;
        chk("p3_c7_valid", 64'(out_valid), 64'd0);
        step();
        #1;
        chk("p3_c8_valid", 64'(out_valid), 64'd1);
        chk("p3_c8_pc", 64'(out_pc), 64'd15);
        for (int k = 8; k < 12; k++) step();
        out_ready = 1'b0;
        chk("p3_delivered", 64'(n_del), 64'd4);

        // Jump and branch together: jump wins.
        do_reset(1'b1);
        expect_run(3, 10);
        jump_valid = 1'b1; jump_dest = 5'd3;
        branch_taken = 1'b1; branch_dest = 5'd23;
        #1;
        chk("p4_c0_mem_req", 64'(mem_req), 64'd0);
        step();
        jump_valid = 1'b0; branch_taken = 1'b0;
        step();
        step();
        #1;
        chk("p4_c3_pc", 64'(out_pc), 64'd3);
        for (int k = 3; k < 7; k++) step();
        out_ready = 1'b0;
        chk("p4_delivered", 64'(n_del), 64'd4);

        // Branch to 30: PC wraps 31 -> 0.
        do_reset(1'b1);
        expect_run(30, 10);
        branch_taken = 1'b1; branch_dest = 5'd30;
        step();
        branch_taken = 1'b0;
        step();
        step();
        #1;
        chk("p5_c3_pc", 64'(out_pc), 64'd30);
        for (int k = 3; k < 7; k++) step();
        out_ready = 1'b0;
        chk("p5_delivered", 64'(n_del), 64'd4);

        // Mid-operation reset with three entries queued.
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) step();
        chk("p6_pre_count", 64'(q_count), 64'd3);
        rst = 1'b1;
        exp_q.delete();
        expect_run(0, 10);
        step();
        rst = 1'b0;
        n_del = 0;
        out_ready = 1'b1;
        #1;
        chk("p6_r0_count", 64'(q_count), 64'd0);
        chk("p6_r0_valid", 64'(out_valid), 64'd0);
        chk("p6_r0_mem_req", 64'(mem_req), 64'd1);
        chk("p6_r0_addr", 64'(mem_addr), 64'd0);
        step();
        #1;
        chk("p6_r1_valid", 64'(out_valid), 64'd0);
        step();
        #1;
        chk("p6_r2_valid", 64'(out_valid), 64'd1);
        chk("p6_r2_pc", 64'(out_pc), 64'd0);
        for (int k = 2; k < 6; k++) step();
        out_ready = 1'b0;
        chk("p6_delivered", 64'(n_del), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised successor to the single-register fetch stage. It drives a program address, captures instructions returned by an external program memory with 1-cycle read latency, and buffers them in a FIFO of QDEPTH entries.
- Each entry holds an instruction plus its PC.
- Delivery to decode uses a valid/ready handshake, replacing the old hazard stall input.
- A jump or taken branch flushes the queue and squashes the in-flight read.

Parameters:
PC_W, 5, program counter width; the address space is 2^PC_W words.
INSTR_W, 32, instruction width.
QDEPTH, 4, instruction queue depth in entries; legal range 2..16, power of two not required.
RESET_PC, 0, fetch address after reset; PC_W bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
jump_valid  input  1  unconditional redirect request.
jump_dest  input  PC_W  jump target.
branch_taken  input  1  taken-branch redirect request.
branch_dest  input  PC_W  branch target.
mem_req  output  1  combinational; a read of mem_addr is issued this cycle.
mem_addr  output  PC_W  combinational; equals fpc.
mem_rdata  input  INSTR_W  instruction for the address requested in the previous cycle.
out_valid  output  1  queue head is valid.
out_ready  input  1  decode accepts the head this cycle.
out_instr  output  INSTR_W  head instruction.
out_pc  output  PC_W  PC of the head instruction.
q_count  output  clog2(QDEPTH+1)  current queue occupancy.

Behaviour:
Reset (rst=1 at an edge):
- fpc <= RESET_PC.
- Queue emptied: q_count=0, out_valid=0.
- inflight=0.
- out_instr and out_pc are 0 while the queue is empty.
- rst has priority over every other input.
- A reset mid-operation discards all queued and in-flight instructions.

Redirect:
- redirect = jump_valid | branch_taken.
- target = jump_dest if jump_valid, else branch_dest; jump wins over branch.
- In the redirect cycle: mem_req=0 and out_valid is forced to 0, so no handshake completes.
- At the edge: fpc <= target, queue flushed, inflight <= 0, which squashes any mem_rdata that would arrive next cycle.

Issue:
- pop = out_valid & out_ready.
- mem_req = !rst & !redirect & (q_count + inflight - pop < QDEPTH).
- When mem_req=1: fpc <= fpc + 1 modulo 2^PC_W (PC_W-1 all-ones wraps to 0), inflight <= 1, inflight_pc <= fpc. Otherwise inflight <= 0.

Capture:
- If inflight=1 and there is no redirect this cycle, {mem_rdata, inflight_pc} is pushed at the edge.
- The room check in Issue guarantees the push never overflows.
- Push and pop in the same cycle are legal; q_count is unchanged.

Output:
- out_valid = (q_count != 0) & !redirect.
- Head fields stay stable while out_valid=1 and out_ready=0.
- Entries leave in program order.

Latency and throughput:
- Reset released at edge E0: mem_req=1 with addr RESET_PC in cycle 0.
- Data is pushed at E2; out_valid=1 with out_pc=RESET_PC in cycle 2.
- Same 2-cycle latency after a redirect, measured from the redirect edge.
- Sustained throughput is 1 instruction per cycle with out_ready held high, for any QDEPTH >= 2.

Storage: circular buffer with rd_ptr and wr_ptr modulo QDEPTH, plus a count register; full when count = QDEPTH, empty when count = 0.

Test Plan:
- Reset, then out_ready=1, no redirects, memory word[i]=i -> out_valid first in cycle 2 with out_pc=0; then one instruction per cycle, out_pc 1,2,3…; q_count stays at or below 1.
- out_ready=0 from reset -> q_count saturates at 4 and mem_req stays 0 once q_count + inflight = 4. Raise out_ready -> PCs 0,1,2,3,4… delivered with no loss or duplicate.
- Queue holding PCs 5..7 plus one read in flight, jump_valid=1 with jump_dest=15 -> in the redirect cycle out_valid=0, mem_req=0. The next delivered out_pc is 15, 2 cycles later; PCs 5..8 never appear.
- jump_valid=1 (dest 3) and branch_taken=1 (dest 23) in the same cycle -> fetch resumes at 3; 23 never appears.
- Run from PC 30 with PC_W=5 -> out_pc sequence 30, 31, 0, 1.
- Assert rst for one cycle while the queue holds 3 entries -> next cycle q_count=0 and out_valid=0; delivery restarts at RESET_PC after 2 cycles.
